// File: rtl/decode_shift_pkg.sv
// Shared constants for the hex-to-7-segment streaming block.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high.
package decode_shift_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Common-anode displays want every pattern, blank included, inverted.
  function automatic logic [7:0] seg_polarity(input logic [7:0] seg, input bit invert);
    return invert ? ~seg : seg;
  endfunction

endpackage

// File: rtl/decode_shift_seg7_hex_decoder.sv
// Combinational 4-bit hex nibble to 7-segment pattern lookup.
// Letters render as A b C d E F; dp is never lit.
module seg7_hex_decoder
  import decode_shift_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/decode_shift.sv
// Snapshots a counter on trigger and streams its nibbles LSN first as 7-segment
// patterns, one per clock, with a digit-select token during the first digit.
module decode_shift
  import decode_shift_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DIGITS,
  parameter bit          SEG_INVERT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] cnt_in,
  input  logic                    trigger,
  output logic [7:0]              segOut,
  output logic                    shiftOut
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [IdxW-1:0] FirstIdx = (NUM_DIGITS > 1) ? IdxW'(1) : '0;
  localparam logic [7:0] SegIdle = seg_polarity(SEG_BLANK, SEG_INVERT);

  logic [4*NUM_DIGITS-1:0] snap;
  logic [IdxW-1:0]         idx;
  logic                    busy;
  logic [3:0]              nibble;
  logic [7:0]              seg_dec;

  // Step 0 decodes straight from cnt_in so the first digit appears on the trigger edge.
  assign nibble = busy ? snap[{idx, 2'b00} +: 4] : cnt_in[3:0];

  seg7_hex_decoder u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // idx returns to 0 after the last digit; busy with idx==0 marks the mandatory idle edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap     <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      segOut   <= SegIdle;
      shiftOut <= 1'b0;
    end else if (!busy) begin
      if (trigger) begin
        snap     <= cnt_in;
        busy     <= 1'b1;
        idx      <= FirstIdx;
        segOut   <= seg_polarity(seg_dec, SEG_INVERT);
        shiftOut <= 1'b1;
      end
    end else if (idx == '0) begin
      busy     <= 1'b0;
      segOut   <= SegIdle;
      shiftOut <= 1'b0;
    end else begin
      segOut   <= seg_polarity(seg_dec, SEG_INVERT);
      shiftOut <= 1'b0;
      idx      <= (idx == LastIdx) ? '0 : idx + IdxW'(1);
    end
  end

endmodule

// File: tb/tb_decode_shift.sv
// Self-checking bench for decode_shift: expected {segOut,shiftOut} pairs are queued
// when a sequence is started and popped one per clock, sampled 1ns after the edge.
module tb_decode_shift;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cnt_in = '0;
  logic        trigger = 1'b0;
  logic [7:0]  segOut;
  logic        shiftOut;

  int checks = 0;
  int failures = 0;

  logic [8:0] sb[$];
  logic [8:0] exp;
  logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  decode_shift dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .trigger  (trigger),
    .segOut   (segOut),
    .shiftOut (shiftOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_seq(input logic [31:0] v);
    for (int d = 0; d < 8; d++) sb.push_back({tbl[v[d*4 +: 4]], (d == 0)});
    sb.push_back({8'h00, 1'b0});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trigger = 1'b0;
    cnt_in = 32'h12345678;
    @(posedge clk); #1;
    checks++;
    if ({segOut, shiftOut} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset: got seg=%02h shift=%0b, want seg=00 shift=0", segOut, shiftOut);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back({8'h00, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_basic();
    cnt_in = 32'h00654321;
    trigger = 1'b1;
    push_seq(cnt_in);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL basic cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_full_decode();
    cnt_in = 32'hFEDCBA98;
    trigger = 1'b1;
    push_seq(cnt_in);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0;
      cnt_in = $urandom;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL full_decode cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_trigger_busy();
    cnt_in = 32'h89ABCDEF;
    trigger = 1'b1;
    push_seq(cnt_in);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 4) trigger = 1'b0;
      cnt_in = $urandom;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL trigger_busy cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
      if (i == 3) trigger = 1'b1;
    end
    for (int i = 0; i < 2; i++) sb.push_back({8'h00, 1'b0});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL trigger_busy_idle cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
  endtask

  task automatic test_trigger_held();
    int k;
    trigger = 1'b1;
    for (k = 0; k < 20; k++) begin
      cnt_in = $urandom;
      if (k % 9 == 0) push_seq(cnt_in);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL trigger_held cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 k, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
    trigger = 1'b0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL trigger_held_tail cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 k, segOut, shiftOut, exp[8:1], exp[0]);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    cnt_in = 32'hA5A51234;
    trigger = 1'b1;
    push_seq(cnt_in);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL reset_mid_pre cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({segOut, shiftOut} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_async: got seg=%02h shift=%0b, want seg=00 shift=0",
               segOut, shiftOut);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({segOut, shiftOut} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_release: got seg=%02h shift=%0b, want seg=00 shift=0",
               segOut, shiftOut);
    end
    cnt_in = 32'h0BADF00D;
    trigger = 1'b1;
    push_seq(cnt_in);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      trigger = 1'b0;
      exp = sb.pop_front();
      checks++;
      if ({segOut, shiftOut} !== exp) begin
        failures++;
        $display("FAIL reset_mid_restart cyc%0d: got seg=%02h shift=%0b, want seg=%02h shift=%0b",
                 i, segOut, shiftOut, exp[8:1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_decode();
    test_trigger_busy();
    test_trigger_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
